// File: rtl/sram_rd_streamer.sv
// Streams a burst of consecutive SRAM words to a valid/ready consumer.
// A 2-entry FIFO plus a Q bypass keeps full throughput without ever dropping a word.
module sram_rd_streamer #(
    parameter int width = 64,
    parameter int num   = 2048
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [10:0]      base_addr,
    input  logic [11:0]      len,
    output logic             busy,
    output logic             done,
    output logic             CEN,
    output logic             WEN,
    output logic [10:0]      A,
    input  logic [width-1:0] Q,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam logic [10:0] LAST_ADDR = 11'(num - 1);

    state_t           state;
    state_t           state_next;
    logic [10:0]      addr;
    logic [10:0]      next_addr;
    logic [11:0]      rd_left;
    logic [11:0]      xfer_left;
    logic             in_flight;
    logic [width-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             pop;
    logic             fifo_pop;
    logic             push;
    logic             space;
    logic             issue;
    logic [2:0]       pending;

    // The word arriving on Q is visible directly when the FIFO is empty,
    // so it is only stored if it is not consumed in its arrival cycle.
    always_comb begin
        out_valid = (count != 2'd0) || in_flight;
        out_data  = (count != 2'd0) ? fifo_mem[rd_ptr] : Q;
        pop       = out_valid && out_ready;
        fifo_pop  = pop && (count != 2'd0);
        push      = in_flight && !(pop && (count == 2'd0));
        pending   = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
        space     = pending < 3'd2;
        issue     = (state == READ) && space;
        next_addr = (addr == LAST_ADDR) ? 11'd0 : addr + 11'd1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len == 12'd0) ? FIN : READ;
            READ:    if (issue && rd_left == 12'd1) state_next = DRAIN;
            DRAIN:   if (pop && xfer_left == 12'd1) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == READ) || (state == DRAIN);
    assign done = (state == FIN);
    assign CEN  = !issue;
    assign WEN  = 1'b1;
    assign A    = addr;

    // A stays on the last address read so it holds steady once the burst ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= 11'd0;
            rd_left   <= 12'd0;
            xfer_left <= 12'd0;
            in_flight <= 1'b0;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            state     <= state_next;
            in_flight <= issue;
            if (state == IDLE) begin
                if (start && len != 12'd0) begin
                    addr      <= base_addr;
                    rd_left   <= len;
                    xfer_left <= len;
                end
            end else begin
                if (issue) begin
                    rd_left <= rd_left - 12'd1;
                    if (rd_left != 12'd1) addr <= next_addr;
                end
                if (pop) xfer_left <= xfer_left - 12'd1;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (fifo_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= Q;
    end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed bench for sram_rd_streamer with a behavioural SRAM holding mem[i]=i.
module tb_sram_rd_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] len;
    logic        busy;
    logic        done;
    logic        CEN;
    logic        WEN;
    logic [10:0] A;
    logic [63:0] Q;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic [63:0] mem [2048];
    int          checks;
    int          errors;

    sram_rd_streamer #(.width(64), .num(2048)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .CEN(CEN),
        .WEN(WEN),
        .A(A),
        .Q(Q),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!CEN) Q <= mem[A];
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one burst and checks every cycle until done (or a cycle budget expires).
    task automatic applyStimulus(input logic [10:0] b, input logic [11:0] n,
                                 input bit rnd, input bit poke);
        int          cyc;
        int          got;
        int          issued;
        int          bound;
        bit          fin;
        bit          prevStall;
        bit          popNow;
        logic [63:0] prevData;
        logic [10:0] aPrev;
        cyc       = 0;
        got       = 0;
        issued    = 0;
        fin       = 1'b0;
        prevStall = 1'b0;
        prevData  = '0;
        bound     = int'(n) * 4 + 20;
        aPrev     = A;
        base_addr = b;
        len       = n;
        start     = 1'b1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fin && cyc < bound) begin
            @(negedge clk);
            popNow = out_valid && out_ready;
            if (!rnd) checkOutput("valid", out_valid, (cyc >= 2 && cyc < int'(n) + 2));
            checkOutput("busy", busy, (n != 0 && cyc >= 1 && !done));
            checkOutput("wen", WEN, 1'b1);
            if (prevStall) begin
                checkOutput("stall_valid", out_valid, 1'b1);
                checkOutput("stall_data", out_data, prevData);
            end
            if (!CEN) begin
                checkOutput("cen_space", ((issued - got - (popNow ? 1 : 0)) < 2), 1'b1);
                checkOutput("over_issue", (issued < int'(n)), 1'b1);
                checkOutput("addr", A, 64'((int'(b) + issued) % 2048));
                issued++;
            end
            if (popNow) begin
                checkOutput("extra_word", (got < int'(n)), 1'b1);
                checkOutput("data", out_data, mem[(int'(b) + got) % 2048]);
                got++;
            end
            if (done) begin
                if (!rnd) checkOutput("done_cyc", cyc, (n == 0) ? 1 : int'(n) + 2);
                checkOutput("done_words", got, n);
                checkOutput("issued", issued, n);
                fin = 1'b1;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            stepCycle();
            cyc++;
            start = 1'b0;
            if (poke && cyc == 3) begin
                start     = 1'b1;
                base_addr = b + 11'd500;
                len       = 12'd3;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!fin) checkOutput("timeout", 1'b0, 1'b1);
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("done_pulse", done, 1'b0);
        checkOutput("idle_cen", CEN, 1'b1);
        checkOutput("idle_valid", out_valid, 1'b0);
        checkOutput("idle_addr", A, (n == 0) ? 64'(aPrev) : 64'((int'(b) + int'(n) - 1) % 2048));
        stepCycle();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Q         = '0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 64'(i);

        stepCycle();
        stepCycle();
        @(negedge clk);
        checkOutput("rst_cen", CEN, 1'b1);
        checkOutput("rst_wen", WEN, 1'b1);
        checkOutput("rst_a", A, 11'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_valid", out_valid, 1'b0);

        // reset wins over a simultaneous start
        stepCycle();
        start     = 1'b1;
        base_addr = 11'd7;
        len       = 12'd5;
        stepCycle();
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("prio_busy", busy, 1'b0);
            checkOutput("prio_cen", CEN, 1'b1);
            checkOutput("prio_done", done, 1'b0);
            stepCycle();
        end

        applyStimulus(11'd5, 12'd4, 1'b0, 1'b0);
        applyStimulus(11'd2046, 12'd4, 1'b0, 1'b0);
        applyStimulus(11'd30, 12'd8, 1'b1, 1'b0);
        applyStimulus(11'd9, 12'd0, 1'b0, 1'b0);
        applyStimulus(11'd200, 12'd6, 1'b0, 1'b1);
        applyStimulus(11'd2044, 12'd8, 1'b1, 1'b0);

        // abort a len=10 burst after three words have gone out
        base_addr = 11'd20;
        len       = 12'd10;
        start     = 1'b1;
        out_ready = 1'b1;
        stepCycle();
        start = 1'b0;
        stepCycle();
        stepCycle();
        stepCycle();
        @(negedge clk);
        checkOutput("pre_rst_data", out_data, mem[22]);
        stepCycle();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", out_valid, 1'b0);
        checkOutput("abort_cen", CEN, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_a", A, 11'd0);
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            @(negedge clk);
            checkOutput("abort_no_done", done, 1'b0);
        end
        stepCycle();
        applyStimulus(11'd100, 12'd2, 1'b0, 1'b0);

        applyStimulus(11'd0, 12'd2048, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
